// File: rtl/microwave_control_unit_if.sv
// Front-panel and timer-side signal bundle for microwave_control_unit.
// master: the controller (drives timer controls, magnetron, alarm, state).
// slave:  the panel/timer side (drives keys, buttons, door, timer_done).
interface microwave_control_unit_if;
  logic       key_valid;
  logic [3:0] key_data;
  logic       start_btn;
  logic       stop_btn;
  logic       clear_btn;
  logic       door_closed;
  logic       timer_done;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_enable;
  logic       timer_clearn;
  logic       mag_on;
  logic       alarm;
  logic [1:0] state;

  modport master (
    input  key_valid, key_data, start_btn, stop_btn, clear_btn, door_closed, timer_done,
    output timer_data, timer_loadn, timer_enable, timer_clearn, mag_on, alarm, state
  );

  modport slave (
    output key_valid, key_data, start_btn, stop_btn, clear_btn, door_closed, timer_done,
    input  timer_data, timer_loadn, timer_enable, timer_clearn, mag_on, alarm, state
  );
endinterface

// File: rtl/microwave_control_unit.sv
// Microwave oven sequencing controller: keypad digit entry into the countdown
// timer, seconds prescaler gating the timer count, cook/pause/done FSM and
// end-of-cook alarm. All outputs are registered.
// Optional feature macro: MWC_DOOR_INTERLOCK_EN (door interlock on start,
// cook and alarm). Left undefined, door_closed is ignored.
module microwave_control_unit #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned MAX_DIGITS   = 3,
  parameter int unsigned ALARM_CYCLES = 100
) (
  input logic                      CLK,
  input logic                      clearn,
  microwave_control_unit_if.master mwc
);

  localparam int unsigned PW = ($clog2(TICK_DIV) > 26) ? $clog2(TICK_DIV) : 26;
  localparam int unsigned DW = ($clog2(MAX_DIGITS + 1) > 1) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam int unsigned AW = ($clog2(ALARM_CYCLES + 1) > 1) ? $clog2(ALARM_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   digit_cnt_q;
  logic [PW-1:0]   presc_q;
  logic [AW-1:0]   alarm_cnt_q;
  logic            start_q;
  logic            stop_q;
  logic            clear_q;
  logic [3:0]      timer_data_q;
  logic            timer_loadn_q;
  logic            timer_enable_q;
  logic            timer_clearn_q;
  logic            mag_on_q;
  logic            alarm_q;

  logic            start_ev;
  logic            stop_ev;
  logic            clear_ev;
  logic            door_ok;
  logic            door_open;
  logic            key_ok;

  // Rising-edge button events against last cycle's sampled level
  assign start_ev = mwc.start_btn & ~start_q;
  assign stop_ev  = mwc.stop_btn  & ~stop_q;
  assign clear_ev = mwc.clear_btn & ~clear_q;
  assign key_ok   = mwc.key_valid && (mwc.key_data <= 4'd9) && (digit_cnt_q < DW'(MAX_DIGITS));

`ifdef MWC_DOOR_INTERLOCK_EN
  assign door_ok   = mwc.door_closed;
  assign door_open = ~mwc.door_closed;
`else
  logic unused_door;
  assign unused_door = mwc.door_closed;
  assign door_ok     = 1'b1;
  assign door_open   = 1'b0;
`endif

  // Control FSM with registered outputs; timer pulses default inactive each cycle
  always_ff @(posedge CLK) begin
    if (!clearn) begin
      state_q        <= ST_IDLE;
      digit_cnt_q    <= '0;
      presc_q        <= '0;
      alarm_cnt_q    <= '0;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      clear_q        <= 1'b0;
      timer_data_q   <= 4'd0;
      timer_loadn_q  <= 1'b1;
      timer_enable_q <= 1'b0;
      timer_clearn_q <= 1'b0;
      mag_on_q       <= 1'b0;
      alarm_q        <= 1'b0;
    end else begin
      start_q        <= mwc.start_btn;
      stop_q         <= mwc.stop_btn;
      clear_q        <= mwc.clear_btn;
      timer_loadn_q  <= 1'b1;
      timer_enable_q <= 1'b0;
      timer_clearn_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (clear_ev || stop_ev) begin
            timer_clearn_q <= 1'b0;
            digit_cnt_q    <= '0;
          end else if (start_ev && door_ok && (digit_cnt_q != '0)) begin
            presc_q  <= '0;
            mag_on_q <= 1'b1;
            state_q  <= ST_COOK;
          end else if (key_ok) begin
            timer_data_q  <= mwc.key_data;
            timer_loadn_q <= 1'b0;
            digit_cnt_q   <= digit_cnt_q + DW'(1);
          end
        end
        ST_COOK: begin
          if (clear_ev) begin
            timer_clearn_q <= 1'b0;
            digit_cnt_q    <= '0;
            mag_on_q       <= 1'b0;
            state_q        <= ST_IDLE;
          end else if (stop_ev) begin
            mag_on_q <= 1'b0;
            state_q  <= ST_PAUSE;
          end else if (mwc.timer_done) begin
            mag_on_q    <= 1'b0;
            alarm_q     <= 1'b1;
            alarm_cnt_q <= '0;
            state_q     <= ST_DONE;
          end else if (door_open) begin
            mag_on_q <= 1'b0;
            state_q  <= ST_PAUSE;
          end else if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_q        <= '0;
            timer_enable_q <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (clear_ev || stop_ev) begin
            timer_clearn_q <= 1'b0;
            digit_cnt_q    <= '0;
            state_q        <= ST_IDLE;
          end else if (start_ev && door_ok) begin
            mag_on_q <= 1'b1;
            state_q  <= ST_COOK;
          end
        end
        ST_DONE: begin
          if (clear_ev || stop_ev || door_open || (alarm_cnt_q == AW'(ALARM_CYCLES - 1))) begin
            alarm_q        <= 1'b0;
            alarm_cnt_q    <= '0;
            timer_clearn_q <= 1'b0;
            digit_cnt_q    <= '0;
            state_q        <= ST_IDLE;
          end else begin
            alarm_cnt_q <= alarm_cnt_q + AW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mwc.timer_data   = timer_data_q;
  assign mwc.timer_loadn  = timer_loadn_q;
  assign mwc.timer_enable = timer_enable_q;
  assign mwc.timer_clearn = timer_clearn_q;
  assign mwc.mag_on       = mag_on_q;
  assign mwc.alarm        = alarm_q;
  assign mwc.state        = state_q;

endmodule

// File: tb/tb_microwave_control_unit.sv
// Bench for microwave_control_unit: directed scenarios followed by random
// panel activity. A reference model predicts the outputs after each edge and
// queues them; a separate monitor pops and compares after every rising edge.
module tb_microwave_control_unit;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned MAX_DIGITS   = 3;
  localparam int unsigned ALARM_CYCLES = 5;

  typedef struct {
    int data;
    int loadn;
    int enable;
    int clearn;
    int mag;
    int alarm;
    int state;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic CLK = 1'b0;
  logic clearn;
  microwave_control_unit_if mwc();

  microwave_control_unit #(
    .TICK_DIV    (TICK_DIV),
    .MAX_DIGITS  (MAX_DIGITS),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .CLK   (CLK),
    .clearn(clearn),
    .mwc   (mwc)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // stimulus levels applied for the coming edge
  bit       s_rstn, s_kv, s_st, s_sp, s_cl, s_door, s_td;
  logic [3:0] s_kd;

  // reference model state (mode uses the output encoding IDLE/COOK/PAUSE/DONE = 0..3)
  int m_mode, m_digits, m_data, m_cook_edges, m_done_cyc;
  bit m_st_p, m_sp_p, m_cl_p;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_n, act, exp);
    end
  endtask

  // Predict outputs visible after the next rising edge from the current inputs
  task automatic model_step();
    exp_t e;
    bit s_ev, p_ev, c_ev, dok, dopen;
    s_ev = s_st && !m_st_p;
    p_ev = s_sp && !m_sp_p;
    c_ev = s_cl && !m_cl_p;
    m_st_p = s_st; m_sp_p = s_sp; m_cl_p = s_cl;
`ifdef MWC_DOOR_INTERLOCK_EN
    dok = s_door; dopen = !s_door;
`else
    dok = 1'b1; dopen = 1'b0;
`endif
    e.loadn = 1; e.enable = 0; e.clearn = 1;
    if (!s_rstn) begin
      m_mode = 0; m_digits = 0; m_data = 0; m_cook_edges = 0; m_done_cyc = 0;
      m_st_p = 0; m_sp_p = 0; m_cl_p = 0;
      e.clearn = 0;
    end else begin
      case (m_mode)
        0: begin
          if (c_ev || p_ev) begin
            e.clearn = 0; m_digits = 0;
          end else if (s_ev && dok && m_digits != 0) begin
            m_mode = 1; m_cook_edges = 0;
          end else if (s_kv && s_kd <= 9 && m_digits < int'(MAX_DIGITS)) begin
            m_data = int'(s_kd); e.loadn = 0; m_digits++;
          end
        end
        1: begin
          if (c_ev) begin
            m_mode = 0; e.clearn = 0; m_digits = 0;
          end else if (p_ev) m_mode = 2;
          else if (s_td) begin
            m_mode = 3; m_done_cyc = 0;
          end else if (dopen) m_mode = 2;
          else begin
            m_cook_edges++;
            if (m_cook_edges % int'(TICK_DIV) == 0) e.enable = 1;
          end
        end
        2: begin
          if (c_ev || p_ev) begin
            m_mode = 0; e.clearn = 0; m_digits = 0;
          end else if (s_ev && dok) m_mode = 1;
        end
        default: begin
          m_done_cyc++;
          if (c_ev || p_ev || dopen || m_done_cyc == int'(ALARM_CYCLES)) begin
            m_mode = 0; e.clearn = 0; m_digits = 0;
          end
        end
      endcase
    end
    e.data  = m_data;
    e.state = m_mode;
    e.mag   = (m_mode == 1) ? 1 : 0;
    e.alarm = (m_mode == 3) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Apply current stimulus, record the prediction, advance to the next falling edge
  task automatic cyc();
    clearn          = s_rstn;
    mwc.key_valid   = s_kv;
    mwc.key_data    = s_kd;
    mwc.start_btn   = s_st;
    mwc.stop_btn    = s_sp;
    mwc.clear_btn   = s_cl;
    mwc.door_closed = s_door;
    mwc.timer_done  = s_td;
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic key(input int d);
    s_kv = 1'b1; s_kd = 4'(d); cyc();
    s_kv = 1'b0; cyc();
  endtask

  task automatic press(input int which);
    if (which == 0) s_st = 1'b1; else if (which == 1) s_sp = 1'b1; else s_cl = 1'b1;
    cyc();
    s_st = 1'b0; s_sp = 1'b0; s_cl = 1'b0;
    cyc();
  endtask

  // Monitor: compare every registered output shortly after each rising edge
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("timer_data",   32'(mwc.timer_data),   mon_e.data);
      chk("timer_loadn",  32'(mwc.timer_loadn),  mon_e.loadn);
      chk("timer_enable", 32'(mwc.timer_enable), mon_e.enable);
      chk("timer_clearn", 32'(mwc.timer_clearn), mon_e.clearn);
      chk("mag_on",       32'(mwc.mag_on),       mon_e.mag);
      chk("alarm",        32'(mwc.alarm),        mon_e.alarm);
      chk("state",        32'(mwc.state),        mon_e.state);
      cyc_n++;
    end
  end

  initial begin
    s_rstn = 1'b0; s_kv = 1'b0; s_kd = 4'd0; s_st = 1'b0; s_sp = 1'b0;
    s_cl = 1'b0; s_door = 1'b1; s_td = 1'b0;

    // reset and digit entry (fourth digit exceeds the limit)
    idle(2);
    s_rstn = 1'b1;
    idle(2);
    key(2); key(1); key(7); key(9);

    // cook countdown, stop/resume
    press(0);
    idle(13);
    press(1);
    idle(3);
    press(0);
    idle(9);

    // door open mid-cook, then close and start
    s_door = 1'b0; idle(3);
    s_door = 1'b1; idle(1);
    press(0);
    idle(7);

    // timer done -> alarm for ALARM_CYCLES then IDLE
    s_td = 1'b1; cyc(); s_td = 1'b0;
    idle(8);

    // clear and timer_done together in COOK
    key(5); press(0); idle(3);
    s_cl = 1'b1; s_td = 1'b1; cyc();
    s_td = 1'b0; s_cl = 1'b0; idle(3);

    // reset in the middle of COOK
    key(4); press(0); idle(5);
    s_rstn = 1'b0; cyc(); s_rstn = 1'b1; idle(2);

    // illegal key and start with no digits
    key(12); press(0); idle(3);

    // stop held high in DONE-free IDLE clears once
    key(3); s_sp = 1'b1; idle(4); s_sp = 1'b0; idle(2);

    // randomized panel activity
    for (int i = 0; i < 4000; i++) begin
      s_rstn = ($urandom_range(0, 299) != 0);
      s_kv   = ($urandom_range(0, 3) == 0);
      s_kd   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)  s_st   = !s_st;
      if ($urandom_range(0, 19) == 0) s_sp   = !s_sp;
      if ($urandom_range(0, 59) == 0) s_cl   = !s_cl;
      if ($urandom_range(0, 29) == 0) s_door = !s_door;
      s_td = (m_mode == 1) && ($urandom_range(0, 39) == 0);
      if (s_st && !m_st_p) s_kv = 1'b0;
      cyc();
    end

    s_kv = 1'b0; s_st = 1'b0; s_sp = 1'b0; s_cl = 1'b0; s_td = 1'b0; s_rstn = 1'b1;
    idle(2);
    @(posedge CLK);
    #2;
    chk("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/microwave_control_unit.md
# microwave_control_unit

Sequencing controller for the microwave oven's countdown timer datapath (`timer_nivel2`). It accepts keypad digits and shifts them into the timer, gates the timer's count enable with a programmable seconds prescaler, and runs the cook/pause/done state machine from the start, stop, clear and door inputs. It drives the magnetron enable and the end-of-cook alarm, and sits between the front-panel inputs and the timer.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per timer count; legal range 2..2^26.
- `MAX_DIGITS`, 3: maximum digits accepted per entry.
- `ALARM_CYCLES`, 100: alarm duration in clock cycles; legal range ≥1.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `clearn`  in  1  reset; synchronous and active-low.
- `key_valid`  in  1  one-cycle strobe; `key_data` is valid while this is high.
- `key_data`  in  4  keypad digit; values 10..15 are ignored.
- `start_btn`, `stop_btn`, `clear_btn`  in  1 each  level inputs from the buttons; each acts on its rising edge only.
- `door_closed`  in  1  level input; 1 = door shut.
- `timer_done`  in  1  timer reached 00:00.
- `timer_data`  out  4  digit presented to the timer.
- `timer_loadn`  out  1  low for one cycle per accepted digit.
- `timer_enable`  out  1  one-cycle count pulse to the timer.
- `timer_clearn`  out  1  low for one cycle to clear the timer.
- `mag_on`  out  1  magnetron enable.
- `alarm`  out  1  end-of-cook alarm.
- `state`  out  2  current state: IDLE=0, COOK=1, PAUSE=2, DONE=3.

## Operation
- Each button is sampled into a registered copy every cycle. An event is `btn & ~btn_q`. A level held high generates exactly one event.
- **Event priority per cycle:** clear > stop > timer_done > door open > start > key.
- **IDLE**
  - A key with value ≤ 9 and `digit_cnt < MAX_DIGITS` sets `timer_data` to the key value, pulses `timer_loadn` low, and increments `digit_cnt`.
  - Any other key is ignored.
  - A start event with `door_closed=1` and `digit_cnt≠0` clears the prescaler and moves to COOK. Otherwise start is ignored.
  - Clear or stop pulses `timer_clearn` and sets `digit_cnt` to 0.
- **COOK**
  - `mag_on=1`.
  - The prescaler counts 0..TICK_DIV-1. `timer_enable` pulses on the cycle the count wraps.
  - `timer_done` moves to DONE.
  - A stop event or `door_closed=0` moves to PAUSE.
  - A clear event pulses `timer_clearn`, sets `digit_cnt` to 0, and moves to IDLE.
  - Keys are ignored.
- **PAUSE**
  - `mag_on=0`. The prescaler holds its count.
  - A start event with `door_closed=1` returns to COOK and resumes the prescaler from its held count.
  - A stop or clear event pulses `timer_clearn`, sets `digit_cnt` to 0, and moves to IDLE.
- **DONE**
  - `mag_on=0`, `alarm=1`, and the alarm counter runs.
  - After ALARM_CYCLES cycles, or on a stop event, door open, or clear event, the block drops `alarm`, pulses `timer_clearn`, sets `digit_cnt` to 0, and moves to IDLE.
- The prescaler counter is at least 26 bits wide and wraps to 0. `digit_cnt` is ceil(log2(MAX_DIGITS+1)) bits wide and saturates at MAX_DIGITS.

## Timing
- All outputs are registered. An input event sampled at rising edge k updates state and outputs at edge k; they are visible during cycle k+1.
- Reset is synchronous. It acts only at an edge where `clearn=0`, including in the middle of COOK.
- Reset values:
  - `state`=IDLE, `digit_cnt`=0, prescaler 0, alarm counter 0.
  - `timer_data`=0, `timer_loadn`=1, `timer_enable`=0, `mag_on`=0, `alarm`=0.
  - `timer_clearn`=0, so the timer is cleared together with the controller. It is 1 from the first edge with `clearn=1`.
- `timer_loadn`, `timer_clearn` and `timer_enable` are one-cycle pulses. They are never asserted in the same cycle.
- The first `timer_enable` after COOK is entered from IDLE occurs TICK_DIV cycles after the entry edge.
- `mag_on` falls on the same edge that leaves COOK.

## Configuration
- `MWC_DOOR_INTERLOCK_EN`
  - **Defined:** start requires `door_closed=1`, and door open forces COOK→PAUSE and ends DONE.
  - **Undefined:** `door_closed` is ignored everywhere. Start needs only `digit_cnt≠0`, and COOK leaves only on stop, clear or `timer_done`.

## Test plan
- **Reset and digit entry.** Hold `clearn=0` for 2 edges, release, then key 2, 1, 7, 9.
  - Three `timer_loadn` pulses, with `timer_data` = 2, 1, 7.
  - The key 9 produces no pulse, and `digit_cnt`=3.
- **Cook countdown.** TICK_DIV=4, after digits loaded, start with door closed.
  - `state`=COOK and `mag_on=1` next cycle.
  - `timer_enable` pulses every 4 cycles, the first 4 cycles after entry.
- **Door open mid-cook.** Open the door in COOK, then close it and press start.
  - PAUSE with `mag_on=0` and the prescaler count held.
  - COOK resumes with no lost or extra `timer_enable` spacing.
- **Timer done.** Assert `timer_done` in COOK with ALARM_CYCLES=5.
  - DONE with `alarm=1` for exactly 5 cycles.
  - Then one `timer_clearn` pulse and IDLE.
- **Simultaneous events.** Clear and `timer_done` in the same COOK cycle.
  - IDLE and `timer_clearn` pulse; `alarm` never rises.
- **Reset mid-cook and illegal input.** `clearn=0` in COOK; key 12 in IDLE; start with `digit_cnt`=0.
  - Reset gives all reset values at that edge.
  - Key 12 gives no load pulse.
  - Start with no digits stays in IDLE.
